// File: rtl/pipelined_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_instr_decoder
// Purpose  : Decodes 32-bit MIPS-subset instructions into a 5-bit operation
//            code plus register fields, an extended immediate and a jump
//            target.  Decoded entries are queued in a DEPTH-entry FIFO so
//            that fetch and execute can stall independently.
// Ports    : clk, rst_n (async, active low), flush (sync clear of FIFO)
//            in_valid / in_ready / in_instr          - instruction input
//            out_valid / out_ready                   - decoded output
//            out_op, out_rs, out_rt, out_rd, out_shamt, out_imm,
//            out_target, out_illegal                 - FIFO head fields
//            out_level                               - FIFO occupancy
//            stat_clr, stat_decoded, stat_illegal    - only with the macro
// Options  : DECODE_STATS_EN adds saturating push / illegal-push counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_instr_decoder #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4:0]                 out_op,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_shamt,
    output logic [XLEN-1:0]            out_imm,
    output logic [25:0]                out_target,
    output logic                       out_illegal,
`ifdef DECODE_STATS_EN
    input  logic                       stat_clr,
    output logic [CNT_W-1:0]           stat_decoded,
    output logic [CNT_W-1:0]           stat_illegal,
`endif
    output logic [$clog2(DEPTH):0]     out_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Elaboration-time sanity check on the configuration.
    if (XLEN < 16 || XLEN > 64 || DEPTH < 2 || DEPTH > 16 ||
        (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_params
        $error("pipelined_instr_decoder: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] dec_op;

    assign opcode = in_instr[31:26];
    assign funct  = in_instr[5:0];

    always_comb begin
        dec_op = 5'd0;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b100000: dec_op = 5'd1;
                6'b100001: dec_op = 5'd2;
                6'b100100: dec_op = 5'd3;
                6'b011010: dec_op = 5'd4;
                6'b011000: dec_op = 5'd5;
                6'b100101: dec_op = 5'd6;
                6'b100111: dec_op = 5'd7;
                6'b000000: dec_op = 5'd8;
                6'b100010: dec_op = 5'd9;
                6'b100110: dec_op = 5'd10;
                default:   dec_op = 5'd0;
            endcase
        end else begin
            case (opcode)
                6'b000010: dec_op = 5'd11;
                6'b000011: dec_op = 5'd12;
                6'b001000: dec_op = 5'd13;
                6'b001001: dec_op = 5'd14;
                6'b001100: dec_op = 5'd15;
                6'b001101: dec_op = 5'd16;
                6'b000100: dec_op = 5'd17;
                6'b000101: dec_op = 5'd18;
                6'b100011: dec_op = 5'd19;
                6'b101011: dec_op = 5'd20;
                default:   dec_op = 5'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO state
    // Only the low 26 instruction bits are stored: every output field is
    // a slice of them, and the opcode/funct meaning is captured in op.
    // The illegal flag is stored separately so that a reset FIFO drives
    // out_illegal = 0 instead of deriving 1 from a zero op.
    // ------------------------------------------------------------------
    logic [4:0]       op_mem_q  [DEPTH];
    logic [4:0]       op_mem_d  [DEPTH];
    logic [25:0]      fld_mem_q [DEPTH];
    logic [25:0]      fld_mem_d [DEPTH];
    logic             ill_mem_q [DEPTH];
    logic             ill_mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    logic push;
    logic pop;

    assign in_ready  = (level_q < LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid  && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        op_mem_d  = op_mem_q;
        fld_mem_d = fld_mem_q;
        ill_mem_d = ill_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (flush) begin
            // Flush wins over any same-cycle push or pop; storage contents
            // are left alone because they are don't-care once empty.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                op_mem_d[wr_ptr_q]  = dec_op;
                fld_mem_d[wr_ptr_q] = in_instr[25:0];
                ill_mem_d[wr_ptr_q] = (dec_op == 5'd0);
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem_q[i]  <= 5'd0;
                fld_mem_q[i] <= 26'd0;
                ill_mem_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            op_mem_q  <= op_mem_d;
            fld_mem_q <= fld_mem_d;
            ill_mem_q <= ill_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Head-of-FIFO output fields
    // ------------------------------------------------------------------
    logic [4:0]  head_op;
    logic [25:0] head_fld;

    assign head_op  = op_mem_q[rd_ptr_q];
    assign head_fld = fld_mem_q[rd_ptr_q];

    assign out_op      = head_op;
    assign out_rs      = head_fld[25:21];
    assign out_rt      = head_fld[20:16];
    assign out_rd      = head_fld[15:11];
    assign out_shamt   = head_fld[10:6];
    assign out_target  = head_fld;
    assign out_illegal = ill_mem_q[rd_ptr_q];
    assign out_level   = level_q;

    // andi / ori take a zero-extended immediate, everything else is signed.
    always_comb begin
        if (head_op == 5'd15 || head_op == 5'd16) begin
            out_imm = XLEN'(head_fld[15:0]);
        end else begin
            out_imm = XLEN'($signed(head_fld[15:0]));
        end
    end

`ifdef DECODE_STATS_EN
    // ------------------------------------------------------------------
    // Saturating decode statistics; flush does not touch them.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stat_decoded_q, stat_decoded_d;
    logic [CNT_W-1:0] stat_illegal_q, stat_illegal_d;

    always_comb begin
        stat_decoded_d = stat_decoded_q;
        stat_illegal_d = stat_illegal_q;
        if (stat_clr) begin
            stat_decoded_d = '0;
            stat_illegal_d = '0;
        end else if (push) begin
            if (stat_decoded_q != '1) begin
                stat_decoded_d = stat_decoded_q + CNT_W'(1);
            end
            if (dec_op == 5'd0 && stat_illegal_q != '1) begin
                stat_illegal_d = stat_illegal_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_decoded_q <= '0;
            stat_illegal_q <= '0;
        end else begin
            stat_decoded_q <= stat_decoded_d;
            stat_illegal_q <= stat_illegal_d;
        end
    end

    assign stat_decoded = stat_decoded_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_instr_decoder
// Purpose  : Self-checking bench for pipelined_instr_decoder.  A queue-based
//            reference model computes the expected FIFO contents from the
//            instruction encoding rules; a compare process checks the DUT
//            against it on every falling edge, and directed scenarios pin a
//            few literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_instr_decoder;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = 32'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:0]       out_op, out_rs, out_rt, out_rd, out_shamt;
    logic [XLEN-1:0]  out_imm;
    logic [25:0]      out_target;
    logic             out_illegal;
    logic [LVL_W-1:0] out_level;

    pipelined_instr_decoder #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_shamt  (out_shamt),
        .out_imm    (out_imm),
        .out_target (out_target),
        .out_illegal(out_illegal),
        .out_level  (out_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int             op;
        int             rs, rt, rd, shamt;
        logic [XLEN-1:0] imm;
        int             target;
        bit             illegal;
    } exp_t;

    function automatic exp_t model_decode(input logic [31:0] ins);
        int    rfun [10] = '{32, 33, 36, 26, 24, 37, 39, 0, 34, 38};
        int    nops [10] = '{2, 3, 8, 9, 12, 13, 4, 5, 35, 43};
        int    opc  = int'(ins[31:26]);
        int    fn   = int'(ins[5:0]);
        longint v;
        exp_t  e;
        e.op = 0;
        for (int i = 0; i < 10; i++) begin
            if (opc == 0 && fn == rfun[i]) e.op = i + 1;
            if (opc != 0 && opc == nops[i]) e.op = i + 11;
        end
        e.rs      = int'(ins[25:21]);
        e.rt      = int'(ins[20:16]);
        e.rd      = int'(ins[15:11]);
        e.shamt   = int'(ins[10:6]);
        e.target  = int'(ins[25:0]);
        e.illegal = (e.op == 0);
        v = longint'(ins[15:0]);
        if (!(e.op == 15 || e.op == 16) && v >= 32768) v = v - 65536;
        e.imm = v[XLEN-1:0];
        return e;
    endfunction

    exp_t q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit pu, po;
            pu = in_valid && (q.size() < DEPTH);
            po = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (po) void'(q.pop_front());
                if (pu) q.push_back(model_decode(in_instr));
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("out_level", 64'(out_level), 64'(q.size()));
            chk("in_ready",  64'(in_ready),  64'(q.size() < DEPTH));
            if (q.size() != 0) begin
                chk("out_op",      64'(out_op),      64'(q[0].op));
                chk("out_rs",      64'(out_rs),      64'(q[0].rs));
                chk("out_rt",      64'(out_rt),      64'(q[0].rt));
                chk("out_rd",      64'(out_rd),      64'(q[0].rd));
                chk("out_shamt",   64'(out_shamt),   64'(q[0].shamt));
                chk("out_imm",     64'(out_imm),     64'(q[0].imm));
                chk("out_target",  64'(out_target),  64'(q[0].target));
                chk("out_illegal", 64'(out_illegal), 64'(q[0].illegal));
            end
        end
    end

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic iv, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        int rfun [10] = '{32, 33, 36, 26, 24, 37, 39, 0, 34, 38};
        int nops [10] = '{2, 3, 8, 9, 12, 13, 4, 5, 35, 43};
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 2))
            0:       r = {6'd0, r[25:6], 6'(rfun[$urandom_range(0, 9)])};
            1:       r = {6'(nops[$urandom_range(0, 9)]), r[25:0]};
            default: r = r;
        endcase
        return r;
    endfunction

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_level", 64'(out_level), 64'd0);
        chk("rst in_ready",  64'(in_ready),  64'd1);
        chk("rst out_op",    64'(out_op),    64'd0);
        chk("rst out_imm",   64'(out_imm),   64'd0);
        chk("rst out_target",64'(out_target),64'd0);
        chk("rst out_illegal",64'(out_illegal),64'd0);
        @(negedge clk);

        // add $8,$9,$10
        step(1'b1, 32'h012A4020, 1'b1, 1'b0);
        chk("add valid", 64'(out_valid), 64'd1);
        chk("add op",    64'(out_op),    64'd1);
        chk("add rs",    64'(out_rs),    64'd9);
        chk("add rt",    64'(out_rt),    64'd10);
        chk("add rd",    64'(out_rd),    64'd8);
        chk("add illegal", 64'(out_illegal), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("add drained", 64'(out_valid), 64'd0);

        // addi / ori immediate extension
        step(1'b1, 32'h2108FFFF, 1'b1, 1'b0);
        chk("addi op",  64'(out_op),  64'd13);
        chk("addi imm", 64'(out_imm), 64'hFFFFFFFF);
        step(1'b1, 32'h3508FFFF, 1'b1, 1'b0);
        chk("ori op",  64'(out_op),  64'd16);
        chk("ori imm", 64'(out_imm), 64'h0000FFFF);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill to DEPTH with consumer stalled, then attempt a fifth push
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h012A4020 + 32'(i << 11), 1'b0, 1'b0);
        chk("full level", 64'(out_level), 64'(DEPTH));
        chk("full in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'h2108FFFF, 1'b0, 1'b0);
        chk("fifth rejected level", 64'(out_level), 64'(DEPTH));
        chk("full head rd", 64'(out_rd), 64'd8);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ready after pop", 64'(in_ready), 64'd1);
        chk("second rd", 64'(out_rd), 64'd9);
        repeat (DEPTH) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drained level", 64'(out_level), 64'd0);

        // Illegal encodings are buffered and delivered
        step(1'b1, 32'hFC000000, 1'b1, 1'b0);
        chk("ill1 op", 64'(out_op), 64'd0);
        chk("ill1 flag", 64'(out_illegal), 64'd1);
        step(1'b1, 32'h0000003F, 1'b1, 1'b0);
        chk("ill2 op", 64'(out_op), 64'd0);
        chk("ill2 flag", 64'(out_illegal), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a same-cycle push
        repeat (3) step(1'b1, 32'h01495020, 1'b0, 1'b0);
        chk("pre-flush level", 64'(out_level), 64'd3);
        step(1'b1, 32'h2108FFFF, 1'b1, 1'b1);
        chk("flush level", 64'(out_level), 64'd0);
        chk("flush valid", 64'(out_valid), 64'd0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush no delivery", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream with 2 entries held
        step(1'b1, 32'h2108FFFF, 1'b0, 1'b0);
        step(1'b1, 32'h3508FFFF, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(out_valid), 64'd0);
        chk("arst level", 64'(out_level), 64'd0);
        chk("arst op",    64'(out_op),    64'd0);
        chk("arst imm",   64'(out_imm),   64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 32'h01495020, 1'b1, 1'b0);
        chk("post-rst valid", 64'(out_valid), 64'd1);
        chk("post-rst rs",    64'(out_rs),    64'd10);
        chk("post-rst rt",    64'(out_rt),    64'd9);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 99) < 60), rand_instr(),
                 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 99) < 2));
        end
        repeat (DEPTH + 2) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("final level", 64'(out_level), 64'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
